// File: rtl/prog_loader.sv
// UART program loader: receives a little-endian length-prefixed byte stream and
// writes 32-bit instruction words into memory, holding the CPU in reset until done.
module prog_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_uart_rx,
    input  logic              i_start,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_cpu_rst_n,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR} ld_state_t;

    logic              rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t         rx_state_q, rx_state_d;
    logic [15:0]       rx_cnt_q, rx_cnt_d;
    logic [2:0]        rx_bit_q, rx_bit_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic              byte_valid_q, byte_valid_d;
    logic              frame_err_q, frame_err_d;

    ld_state_t         state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [16:0]       rem_q, rem_d;
    logic [1:0]        pack_cnt_q, pack_cnt_d;
    logic [31:0]       pack_q, pack_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [15:0]       len_full;

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q + 16'd1;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = 16'd0;
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                // Mid-start-bit recheck filters short low glitches
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = 16'd0;
                    rx_bit_d = 3'd0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = 16'd0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d     = 16'd0;
                    rx_state_d   = RX_IDLE;
                    byte_valid_d = rx_sync_q;
                    frame_err_d  = !rx_sync_q;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign len_full = {rx_shift_q, len_lo_q};

    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        rem_d      = rem_q;
        pack_cnt_d = pack_cnt_q;
        pack_d     = pack_q;
        addr_d     = addr_q;
        we_d       = 1'b0;
        wdata_d    = wdata_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (i_start) begin
                    state_d    = LEN_LO;
                    pack_cnt_d = 2'd0;
                end
            end
            LEN_LO: begin
                if (frame_err_q) begin
                    state_d = ERR;
                end else if (byte_valid_q) begin
                    len_lo_d = rx_shift_q;
                    state_d  = LEN_HI;
                end
            end
            LEN_HI: begin
                if (frame_err_q) begin
                    state_d = ERR;
                end else if (byte_valid_q) begin
                    if (len_full == 16'd0) begin
                        state_d = DONE;
                    end else if ({1'b0, len_full} > MAX_WORDS) begin
                        state_d = ERR;
                    end else begin
                        state_d    = DATA;
                        addr_d     = '0;
                        rem_d      = {1'b0, len_full};
                        pack_cnt_d = 2'd0;
                    end
                end
            end
            DATA: begin
                // The write cycle retires the word; the last one holds the address
                if (we_q) begin
                    rem_d = rem_q - 17'd1;
                    if (rem_q == 17'd1) begin
                        state_d = DONE;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end else if (frame_err_q) begin
                    state_d = ERR;
                end else if (byte_valid_q) begin
                    pack_d     = {rx_shift_q, pack_q[31:8]};
                    pack_cnt_d = pack_cnt_q + 2'd1;
                    if (pack_cnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = {rx_shift_q, pack_q[31:8]};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d      = (state_d == LEN_LO) || (state_d == LEN_HI) || (state_d == DATA);
        done_d      = (state_d == DONE);
        err_d       = (state_d == ERR);
        cpu_rst_n_d = (state_d == DONE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= 16'd0;
            rx_bit_q     <= 3'd0;
            rx_shift_q   <= 8'd0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            state_q      <= IDLE;
            len_lo_q     <= 8'd0;
            rem_q        <= 17'd0;
            pack_cnt_q   <= 2'd0;
            pack_q       <= 32'd0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= 32'd0;
            cpu_rst_n_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            rx_meta_q    <= i_uart_rx;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            rem_q        <= rem_d;
            pack_cnt_q   <= pack_cnt_d;
            pack_q       <= pack_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            cpu_rst_n_q  <= cpu_rst_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign o_imem_we    = we_q;
    assign o_imem_addr  = addr_q;
    assign o_imem_wdata = wdata_q;
    assign o_cpu_rst_n  = cpu_rst_n_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader: serialises byte streams onto the
// UART line and compares captured memory writes and status against a stream model.
module tb_prog_loader;

    localparam int CPB    = 16;
    localparam int ADDR_W = 8;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_uart_rx;
    logic              i_start;
    logic              o_imem_we;
    logic [ADDR_W-1:0] o_imem_addr;
    logic [31:0]       o_imem_wdata;
    logic              o_cpu_rst_n;
    logic              o_busy;
    logic              o_done;
    logic              o_err;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int last_we_cycle = 0;
    int done_rise_cycle = 0;
    logic prev_done = 1'b0;

    logic [7:0]        tx_q[$];
    logic [31:0]       exp_words[$];
    logic [ADDR_W-1:0] obs_addr[$];
    logic [31:0]       obs_data[$];

    prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_uart_rx   (i_uart_rx),
        .i_start     (i_start),
        .o_imem_we   (o_imem_we),
        .o_imem_addr (o_imem_addr),
        .o_imem_wdata(o_imem_wdata),
        .o_cpu_rst_n (o_cpu_rst_n),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Capture every write strobe and note when DONE is first reached
    always @(negedge i_clk) begin
        cycle++;
        if (o_imem_we === 1'b1) begin
            obs_addr.push_back(o_imem_addr);
            obs_data.push_back(o_imem_wdata);
            last_we_cycle = cycle;
            checkOutput("we_while_busy", {31'd0, o_busy}, 32'd1);
        end
        if (o_done === 1'b1 && prev_done !== 1'b1) done_rise_cycle = cycle;
        prev_done = o_done;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    // One 8N1 frame followed by one idle bit time
    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
        i_uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            i_uart_rx = b[i];
            tick(CPB);
        end
        i_uart_rx = stop_bit;
        tick(CPB);
        i_uart_rx = 1'b1;
        tick(CPB);
    endtask

    task automatic pulseStart();
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
    endtask

    // Reference: length word, then words assembled from groups of four bytes
    task automatic buildExpected(output bit exp_err);
        int n;
        n = int'(tx_q[0]) + 256 * int'(tx_q[1]);
        exp_words.delete();
        exp_err = (n > (1 << ADDR_W));
        if (!exp_err) begin
            for (int w = 0; w < n; w++) begin
                exp_words.push_back(32'(int'(tx_q[2 + 4*w])
                                  + (int'(tx_q[3 + 4*w]) << 8)
                                  + (int'(tx_q[4 + 4*w]) << 16))
                                  + (32'(tx_q[5 + 4*w]) << 24));
            end
        end
    endtask

    task automatic compareWrites(input string tag);
        int n;
        checkOutput({tag, "_wr_count"}, obs_data.size(), exp_words.size());
        n = (obs_data.size() < exp_words.size()) ? obs_data.size() : exp_words.size();
        for (int i = 0; i < n; i++) begin
            checkOutput({tag, "_wr_addr"}, 32'(obs_addr[i]), i);
            checkOutput({tag, "_wr_data"}, obs_data[i], exp_words[i]);
        end
    endtask

    // mode 0: plain load, 1: stray i_start mid-data, 2: glitch on the line before the length
    task automatic runLoad(input string tag, input int mode);
        bit exp_err;
        int waited;
        buildExpected(exp_err);
        pulseStart();
        checkOutput({tag, "_busy_on_start"}, {31'd0, o_busy}, 32'd1);
        checkOutput({tag, "_cpu_rst_on_start"}, {31'd0, o_cpu_rst_n}, 32'd0);
        checkOutput({tag, "_done_on_start"}, {31'd0, o_done}, 32'd0);
        checkOutput({tag, "_err_on_start"}, {31'd0, o_err}, 32'd0);
        obs_addr.delete();
        obs_data.delete();
        done_rise_cycle = 0;
        if (mode == 2) begin
            tick(5);
            i_uart_rx = 1'b0;
            tick(CPB / 4);
            i_uart_rx = 1'b1;
            tick(3 * CPB);
            checkOutput({tag, "_glitch_busy"}, {31'd0, o_busy}, 32'd1);
            checkOutput({tag, "_glitch_err"}, {31'd0, o_err}, 32'd0);
        end
        foreach (tx_q[i]) begin
            applyStimulus(tx_q[i], 1'b1);
            if (mode == 1 && i == 3) pulseStart();
        end
        waited = 0;
        while (o_done !== 1'b1 && o_err !== 1'b1 && waited < 50) begin
            tick(1);
            waited++;
        end
        tick(2);
        checkOutput({tag, "_done"}, {31'd0, o_done}, {31'd0, !exp_err});
        checkOutput({tag, "_err"}, {31'd0, o_err}, {31'd0, exp_err});
        checkOutput({tag, "_cpu_rst_n"}, {31'd0, o_cpu_rst_n}, {31'd0, !exp_err});
        checkOutput({tag, "_busy_end"}, {31'd0, o_busy}, 32'd0);
        compareWrites(tag);
        if (!exp_err && exp_words.size() > 0 && obs_data.size() > 0)
            checkOutput({tag, "_done_latency"}, done_rise_cycle - last_we_cycle, 32'd1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_we"}, {31'd0, o_imem_we}, 32'd0);
        checkOutput({tag, "_addr"}, 32'(o_imem_addr), 32'd0);
        checkOutput({tag, "_wdata"}, o_imem_wdata, 32'd0);
        checkOutput({tag, "_cpu_rst_n"}, {31'd0, o_cpu_rst_n}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
        checkOutput({tag, "_done"}, {31'd0, o_done}, 32'd0);
        checkOutput({tag, "_err"}, {31'd0, o_err}, 32'd0);
    endtask

    task automatic randomStream(input int n);
        tx_q.delete();
        tx_q.push_back(8'(n));
        tx_q.push_back(8'd0);
        for (int i = 0; i < 4 * n; i++) tx_q.push_back(8'($urandom));
    endtask

    initial begin
        i_rst = 1'b0;
        i_uart_rx = 1'b1;
        i_start = 1'b0;
        tick(5);
        checkResetValues("reset");
        i_rst = 1'b1;
        tick(CPB);
        checkResetValues("idle");

        tx_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        runLoad("nominal", 0);

        tx_q = '{8'h00, 8'h00};
        runLoad("empty", 0);

        tx_q = '{8'h01, 8'h01};
        runLoad("oversize", 0);

        // Framing error inside the first data word
        pulseStart();
        obs_addr.delete();
        obs_data.delete();
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'hAA, 1'b1);
        applyStimulus(8'hBB, 1'b1);
        applyStimulus(8'hCC, 1'b0);
        tick(4);
        checkOutput("framing_err", {31'd0, o_err}, 32'd1);
        checkOutput("framing_busy", {31'd0, o_busy}, 32'd0);
        checkOutput("framing_cpu_rst_n", {31'd0, o_cpu_rst_n}, 32'd0);
        checkOutput("framing_wr_count", obs_data.size(), 32'd0);
        randomStream(1);
        runLoad("framing_reload", 0);

        tx_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        runLoad("glitch", 2);

        for (int k = 0; k < 6; k++) begin
            randomStream($urandom_range(1, 5));
            runLoad("random", ($urandom_range(0, 1) == 1) ? 1 : 0);
        end

        // Reset two words into a four-word load, mid-byte
        randomStream(4);
        pulseStart();
        obs_addr.delete();
        obs_data.delete();
        for (int i = 0; i < 10; i++) applyStimulus(tx_q[i], 1'b1);
        checkOutput("midreset_pre_writes", obs_data.size(), 32'd2);
        i_uart_rx = 1'b0;
        tick(3 * CPB);
        i_rst = 1'b0;
        tick(1);
        checkResetValues("midreset");
        tick(2);
        i_uart_rx = 1'b1;
        i_rst = 1'b1;
        tick(2 * CPB);
        for (int i = 10; i < tx_q.size(); i++) applyStimulus(tx_q[i], 1'b1);
        tick(20);
        checkOutput("midreset_post_writes", obs_data.size(), 32'd2);
        checkOutput("midreset_busy", {31'd0, o_busy}, 32'd0);
        checkOutput("midreset_done", {31'd0, o_done}, 32'd0);
        checkOutput("midreset_cpu_rst_n", {31'd0, o_cpu_rst_n}, 32'd0);

        randomStream($urandom_range(1, 4));
        runLoad("after_reset", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
